// File: rtl/pxs_vga_stream_gen_if.sv
// Pixel-stream bundle: enable in, 26-bit RGB stream plus frame marker/counter out.
interface pxs_vga_stream_gen_if;
  logic        en;
  logic [25:0] RGBStr_o;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  // Generator side drives the stream and consumes the enable.
  modport master (
    input  en,
    output RGBStr_o,
    output frame_start,
    output frame_cnt
  );

  // Downstream side (or bench) drives the enable and consumes the stream.
  modport slave (
    output en,
    input  RGBStr_o,
    input  frame_start,
    input  frame_cnt
  );
endinterface

// File: rtl/pxs_vga_stream_gen.sv
// Head of the pixel-stream chain: raster counters, sync/active decode and a
// registered 26-bit stream {RGB, XC, YC, HS, VS, Active}, plus frame marker/count.
module pxs_vga_stream_gen #(
  parameter int unsigned H_ACT    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACT    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter logic [2:0]  COLOR_BG = 3'b000
) (
  input logic                  px_clk,
  input logic                  px_rst_n,
  pxs_vga_stream_gen_if.master bus
);

  localparam int unsigned H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  // XC/YC are 10 bits wide, so a raster wider or taller than 1024 cannot be encoded.
  if ((H_TOT > 1024) || (V_TOT > 1024)) begin : g_size_check
    $error("pxs_vga_stream_gen: H_TOT and V_TOT must both be <= 1024");
  end

  // Thresholds are 11 bits so a boundary equal to 1024 still compares correctly.
  localparam logic [10:0] HActEnd = 11'(H_ACT);
  localparam logic [10:0] HsStart = 11'(H_ACT + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_ACT + H_FP + H_SYNC);
  localparam logic [10:0] HLast   = 11'(H_TOT - 1);
  localparam logic [10:0] VActEnd = 11'(V_ACT);
  localparam logic [10:0] VsStart = 11'(V_ACT + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACT + V_FP + V_SYNC);
  localparam logic [10:0] VLast   = 11'(V_TOT - 1);

  localparam logic [25:0] StreamRst = {3'b000, 10'd0, 10'd0, ~HS_POL, ~VS_POL, 1'b0};

  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic [25:0] r_stream;
  logic        r_frame_start;
  logic [7:0]  r_frame_cnt;

  logic [9:0]  w_hc_nxt;
  logic [9:0]  w_vc_nxt;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_active;
  logic        w_hs;
  logic        w_vs;
  logic        w_origin;

  // Counter advance and sync/active decode of the current raster position.
  always_comb begin
    w_h_last = ({1'b0, r_hc} == HLast);
    w_v_last = ({1'b0, r_vc} == VLast);
    w_hc_nxt = r_hc + 10'd1;
    w_vc_nxt = r_vc;
    if (w_h_last) begin
      w_hc_nxt = 10'd0;
      w_vc_nxt = w_v_last ? 10'd0 : (r_vc + 10'd1);
    end
    w_active = ({1'b0, r_hc} < HActEnd) && ({1'b0, r_vc} < VActEnd);
    w_hs     = (({1'b0, r_hc} >= HsStart) && ({1'b0, r_hc} < HsEnd)) ? HS_POL : ~HS_POL;
    w_vs     = (({1'b0, r_vc} >= VsStart) && ({1'b0, r_vc} < VsEnd)) ? VS_POL : ~VS_POL;
    w_origin = (r_hc == 10'd0) && (r_vc == 10'd0);
  end

  // Raster position, stream register and frame bookkeeping; all frozen while en is low.
  always_ff @(posedge px_clk or negedge px_rst_n) begin
    if (!px_rst_n) begin
      r_hc          <= 10'd0;
      r_vc          <= 10'd0;
      r_stream      <= StreamRst;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 8'd0;
    end else if (bus.en) begin
      r_hc          <= w_hc_nxt;
      r_vc          <= w_vc_nxt;
      // Coordinate and its decoded sync/active are captured together.
      r_stream      <= {COLOR_BG, r_hc, r_vc, w_hs, w_vs, w_active};
      r_frame_start <= w_origin;
      if (w_origin) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end else begin
      r_frame_start <= 1'b0;
    end
  end

  assign bus.RGBStr_o    = r_stream;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_cnt   = r_frame_cnt;

endmodule
